epl_mem_access_ctrl: RTL and testbench

- Host-side access controller that drives the EPL FFRAM bit-cell memory array.
- Accepts single-word read and write requests over a ready/request handshake and decodes the row address into a one-hot wordline.
- Generates column write enables and data, and issues the read strobe, the column-address tag and the registered read-data capture.
- Sits between the system bus adapter and the memory array; it is the initiator for the array's read/write interface.

---
 rtl/epl_mem_access_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_epl_mem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/epl_mem_access_ctrl.sv
// Host-side access controller for the EPL FFRAM array: single-word read/write with one-hot wordline drive.
// Optional `EPL_WRITE_VERIFY_EN: each write is followed by a read-back compare on the same row.
module epl_mem_access_ctrl #(
    parameter int ROW    = 16,
    parameter int COLUMN = 16,
    parameter int ROW_AW = 4,
    parameter int TAG_W  = 2,
    parameter int RD_TMO = 4
) (
    input  logic              pClk_i,
    input  logic              nRst_i,
    input  logic              pReq_i,
    input  logic              pWr_i,
    input  logic [ROW_AW-1:0] pAddr_i,
    input  logic [COLUMN-1:0] pMask_i,
    input  logic [COLUMN-1:0] pWdata_i,
    input  logic [TAG_W-1:0]  pTag_i,
    output logic              pReady_o,
    output logic              pAck_o,
    output logic              pErr_o,
    output logic              pRvalid_o,
    output logic [COLUMN-1:0] pRdata_o,
    output logic [TAG_W-1:0]  pRtag_o,
    output logic [ROW-1:0]    pWl_o,
    output logic [COLUMN-1:0] pWe_o,
    output logic [COLUMN-1:0] pDi_o,
    output logic              pRead0_o,
    output logic [TAG_W-1:0]  pAcy1_o,
    input  logic [COLUMN-1:0] pDto_i,
    input  logic              pRead01_i,
    input  logic [TAG_W-1:0]  pAcy2_i
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDW} state_t;

    localparam logic [ROW_AW:0] ROW_LIM = (ROW_AW+1)'(ROW);
    localparam logic [3:0]      TMO     = 4'(RD_TMO);

    state_t              state_q, state_d;
    logic [ROW_AW-1:0]   addr_q, addr_d;
    logic [COLUMN-1:0]   mask_q, mask_d;
    logic [COLUMN-1:0]   wdata_q, wdata_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;
    logic [COLUMN-1:0]   rdata_q, rdata_d;
    logic [TAG_W-1:0]    rtag_q, rtag_d;
`ifdef EPL_WRITE_VERIFY_EN
    logic                wr_q, wr_d;
`endif

    logic                accept;
    logic                in_range;
    logic [ROW-1:0]      wl_hit;

    assign accept   = (state_q == S_IDLE) && pReq_i;
    assign in_range = ({1'b0, pAddr_i} < ROW_LIM);

    for (genvar gi = 0; gi < ROW; gi++) begin : g_wl
        localparam logic [ROW_AW-1:0] IDX = ROW_AW'(gi);
        assign wl_hit[gi] = (addr_q == IDX);
    end

    always_ff @(posedge pClk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rtag_q   <= '0;
`ifdef EPL_WRITE_VERIFY_EN
            wr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rtag_q   <= rtag_d;
`ifdef EPL_WRITE_VERIFY_EN
            wr_q     <= wr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rtag_d   = rtag_q;
`ifdef EPL_WRITE_VERIFY_EN
        wr_d     = wr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = pAddr_i;
                    mask_d  = pMask_i;
                    wdata_d = pWdata_i;
                    tag_d   = pTag_i;
`ifdef EPL_WRITE_VERIFY_EN
                    wr_d    = pWr_i;
`endif
                    // Out-of-range rows never touch the array; complete with error next cycle.
                    if (in_range) begin
                        state_d = pWr_i ? S_WR : S_RD;
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            S_WR: begin
`ifdef EPL_WRITE_VERIFY_EN
                state_d = S_RD;
`else
                state_d = S_IDLE;
                ack_d   = 1'b1;
`endif
            end
            S_RD: begin
                state_d = S_RDW;
                cnt_d   = 4'd1;
            end
            S_RDW: begin
                if (pRead01_i) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
`ifdef EPL_WRITE_VERIFY_EN
                    if (wr_q) begin
                        err_d = |((pDto_i ^ wdata_q) & mask_q);
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = pDto_i;
                        rtag_d   = pAcy2_i;
                    end
`else
                    rvalid_d = 1'b1;
                    rdata_d  = pDto_i;
                    rtag_d   = pAcy2_i;
`endif
                end else if (cnt_q == TMO) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Array strobes decode straight from state so reset drops them without waiting for a clock.
    always_comb begin
        pWl_o    = '0;
        pWe_o    = '0;
        pDi_o    = '0;
        pRead0_o = 1'b0;
        pAcy1_o  = '0;
        case (state_q)
            S_WR: begin
                pWl_o = wl_hit;
                pWe_o = mask_q;
                pDi_o = wdata_q;
            end
            S_RD: begin
                pWl_o    = wl_hit;
                pRead0_o = 1'b1;
                pAcy1_o  = tag_q;
            end
            default: ;
        endcase
    end

    assign pReady_o  = (state_q == S_IDLE);
    assign pAck_o    = ack_q;
    assign pErr_o    = err_q;
    assign pRvalid_o = rvalid_q;
    assign pRdata_o  = rdata_q;
    assign pRtag_o   = rtag_q;

endmodule

// File: tb/tb_epl_mem_access_ctrl.sv
// Bench for epl_mem_access_ctrl: behavioural array model plus a word-level reference of memory contents.
// Honours `EPL_WRITE_VERIFY_EN when compiled with it.
module tb_epl_mem_access_ctrl;

    localparam int ROW    = 12;
    localparam int COLUMN = 16;
    localparam int ROW_AW = 4;
    localparam int TAG_W  = 2;
    localparam int RD_TMO = 4;
`ifdef EPL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              pClk_i = 1'b0;
    logic              nRst_i;
    logic              pReq_i;
    logic              pWr_i;
    logic [ROW_AW-1:0] pAddr_i;
    logic [COLUMN-1:0] pMask_i;
    logic [COLUMN-1:0] pWdata_i;
    logic [TAG_W-1:0]  pTag_i;
    logic              pReady_o;
    logic              pAck_o;
    logic              pErr_o;
    logic              pRvalid_o;
    logic [COLUMN-1:0] pRdata_o;
    logic [TAG_W-1:0]  pRtag_o;
    logic [ROW-1:0]    pWl_o;
    logic [COLUMN-1:0] pWe_o;
    logic [COLUMN-1:0] pDi_o;
    logic              pRead0_o;
    logic [TAG_W-1:0]  pAcy1_o;
    logic [COLUMN-1:0] pDto_i;
    logic              pRead01_i;
    logic [TAG_W-1:0]  pAcy2_i;

    int tests = 0;
    int fails = 0;

    always #5 pClk_i = ~pClk_i;

    epl_mem_access_ctrl #(
        .ROW(ROW), .COLUMN(COLUMN), .ROW_AW(ROW_AW), .TAG_W(TAG_W), .RD_TMO(RD_TMO)
    ) dut (
        .pClk_i(pClk_i), .nRst_i(nRst_i), .pReq_i(pReq_i), .pWr_i(pWr_i),
        .pAddr_i(pAddr_i), .pMask_i(pMask_i), .pWdata_i(pWdata_i), .pTag_i(pTag_i),
        .pReady_o(pReady_o), .pAck_o(pAck_o), .pErr_o(pErr_o), .pRvalid_o(pRvalid_o),
        .pRdata_o(pRdata_o), .pRtag_o(pRtag_o), .pWl_o(pWl_o), .pWe_o(pWe_o),
        .pDi_o(pDi_o), .pRead0_o(pRead0_o), .pAcy1_o(pAcy1_o), .pDto_i(pDto_i),
        .pRead01_i(pRead01_i), .pAcy2_i(pAcy2_i)
    );

    // Bit-cell array model: masked writes, 1-cycle registered read data and tag.
    logic [COLUMN-1:0] arr [ROW];
    bit hold_inv = 1'b0;
    bit stuck0   = 1'b0;

    always @(posedge pClk_i) begin
        pRead01_i <= 1'b0;
        for (int r = 0; r < ROW; r++) begin
            if (pWl_o[r]) begin
                if (pRead0_o && !hold_inv) begin
                    pRead01_i <= 1'b1;
                    pDto_i    <= arr[r] & (stuck0 ? 16'hFFFE : 16'hFFFF);
                    pAcy2_i   <= pAcy1_o;
                end
                arr[r] <= (arr[r] & ~pWe_o) | (pDi_o & pWe_o);
            end
        end
    end

    // Reference: ideal word contents and last successful read.
    logic [COLUMN-1:0] exp_mem [ROW];
    logic [COLUMN-1:0] exp_rdata = '0;
    logic [TAG_W-1:0]  exp_rtag  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic txn(input bit wr, input logic [ROW_AW-1:0] addr, input logic [COLUMN-1:0] mask,
                       input logic [COLUMN-1:0] wdata, input logic [TAG_W-1:0] tag,
                       input bit timeout, input bit noise);
        int lat;
        int exp_lat;
        bit inr;
        bit exp_err;
        bit exp_rv;
        logic [ROW-1:0] onehot;
        inr = (int'(addr) < ROW);
        onehot = '0;
        if (inr) onehot[addr] = 1'b1;
        chk("ready_before", 32'(pReady_o), 32'd1);
        pReq_i = 1'b1; pWr_i = wr; pAddr_i = addr; pMask_i = mask; pWdata_i = wdata; pTag_i = tag;
        hold_inv = timeout;
        @(negedge pClk_i);
        lat = 1;
        if (inr && noise) begin
            pReq_i = 1'b1; pWr_i = 1'($urandom); pAddr_i = 4'($urandom);
            pMask_i = 16'($urandom); pWdata_i = 16'($urandom); pTag_i = 2'($urandom);
        end else begin
            pReq_i = 1'b0;
        end
        chk("t1_wl", 32'(pWl_o), 32'(onehot));
        if (inr && wr) begin
            chk("t1_we", 32'(pWe_o), 32'(mask));
            chk("t1_di", 32'(pDi_o), 32'(wdata));
            chk("t1_read0", 32'(pRead0_o), 32'd0);
        end else if (inr) begin
            chk("t1_read0", 32'(pRead0_o), 32'd1);
            chk("t1_acy1", 32'(pAcy1_o), 32'(tag));
            chk("t1_we", 32'(pWe_o), 32'd0);
        end
        while (!pAck_o && lat < 20) begin
            chk("busy_ready", 32'(pReady_o), 32'd0);
            chk("wl_onehot0", 32'($onehot0(pWl_o)), 32'd1);
            chk("we_read_excl", 32'((|pWe_o) && pRead0_o), 32'd0);
            @(negedge pClk_i);
            lat++;
            pReq_i = 1'b0;
        end
        chk("ack", 32'(pAck_o), 32'd1);
        if (!inr)      exp_lat = 1;
        else if (wr)   exp_lat = VERIFY ? 4 : 2;
        else           exp_lat = 3;
        if (!timeout) chk("latency", 32'(lat), 32'(exp_lat));
        exp_err = !inr || timeout || (wr && VERIFY && stuck0 && mask[0] && wdata[0]);
        exp_rv  = inr && !wr && !timeout;
        if (inr && wr) exp_mem[addr] = (exp_mem[addr] & ~mask) | (wdata & mask);
        if (exp_rv) begin
            exp_rdata = exp_mem[addr];
            exp_rtag  = tag;
        end
        chk("err", 32'(pErr_o), 32'(exp_err));
        chk("rvalid", 32'(pRvalid_o), 32'(exp_rv));
        chk("rdata", 32'(pRdata_o), 32'(exp_rdata));
        chk("rtag", 32'(pRtag_o), 32'(exp_rtag));
        chk("ready_at_ack", 32'(pReady_o), 32'd1);
        chk("wl_at_ack", 32'(pWl_o), 32'd0);
        hold_inv = 1'b0;
        $display("[TB] %s addr=%0d mask=%h wdata=%h tag=%0d tmo=%0d -> lat=%0d err=%0d rdata=%h rtag=%0d",
                 wr ? "WR" : "RD", addr, mask, wdata, tag, timeout, lat, pErr_o, pRdata_o, pRtag_o);
    endtask

    initial begin
        nRst_i = 1'b0;
        pReq_i = 1'b0; pWr_i = 1'b0; pAddr_i = '0; pMask_i = '0; pWdata_i = '0; pTag_i = '0;
        for (int i = 0; i < ROW; i++) exp_mem[i] = '0;
        @(negedge pClk_i);
        @(negedge pClk_i);
        chk("rst_ready", 32'(pReady_o), 32'd1);
        chk("rst_ack", 32'(pAck_o), 32'd0);
        chk("rst_err", 32'(pErr_o), 32'd0);
        chk("rst_rvalid", 32'(pRvalid_o), 32'd0);
        chk("rst_rdata", 32'(pRdata_o), 32'd0);
        chk("rst_wl", 32'(pWl_o), 32'd0);
        chk("rst_we", 32'(pWe_o), 32'd0);
        chk("rst_read0", 32'(pRead0_o), 32'd0);
        nRst_i = 1'b1;
        @(negedge pClk_i);

        // Directed plan
        txn(1'b1, 4'd3, 16'hFFFF, 16'hA5C3, 2'b00, 1'b0, 1'b0);
        txn(1'b0, 4'd3, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b0);
        chk("plan_rd_a5c3", 32'(pRdata_o), 32'h0000A5C3);
        txn(1'b1, 4'd3, 16'h00FF, 16'h0000, 2'b00, 1'b0, 1'b1);
        txn(1'b0, 4'd3, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b1);
        chk("plan_rd_a500", 32'(pRdata_o), 32'h0000A500);
        txn(1'b0, 4'd3, 16'h0000, 16'h0000, 2'b11, 1'b1, 1'b1);
        txn(1'b0, 4'd13, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
        txn(1'b1, 4'd12, 16'hFFFF, 16'h1234, 2'b00, 1'b0, 1'b0);
        txn(1'b1, 4'd11, 16'hFFFF, 16'h8001, 2'b00, 1'b0, 1'b0);
        txn(1'b0, 4'd11, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b0);

        for (int i = 0; i < ROW; i++)
            txn(1'b1, 4'(i), 16'hFFFF, 16'($urandom), 2'b00, 1'b0, 1'($urandom));

        // Reset while waiting in RDW: strobes stay low, no completion appears.
        pReq_i = 1'b1; pWr_i = 1'b0; pAddr_i = 4'd2; pTag_i = 2'b01; hold_inv = 1'b1;
        @(negedge pClk_i);
        pReq_i = 1'b0;
        @(negedge pClk_i);
        @(negedge pClk_i);
        chk("rdw_busy", 32'(pReady_o), 32'd0);
        nRst_i = 1'b0;
        #1;
        chk("rdw_rst_wl", 32'(pWl_o), 32'd0);
        chk("rdw_rst_we", 32'(pWe_o), 32'd0);
        chk("rdw_rst_read0", 32'(pRead0_o), 32'd0);
        chk("rdw_rst_ready", 32'(pReady_o), 32'd1);
        chk("rdw_rst_ack", 32'(pAck_o), 32'd0);
        @(negedge pClk_i);
        chk("rdw_rst_rdata", 32'(pRdata_o), 32'd0);
        nRst_i = 1'b1; hold_inv = 1'b0;
        exp_rdata = '0; exp_rtag = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pClk_i);
            chk("rdw_post_ack", 32'(pAck_o), 32'd0);
        end

        // Reset during WR: strobes drop at once and the write never lands.
        pReq_i = 1'b1; pWr_i = 1'b1; pAddr_i = 4'd4; pMask_i = 16'hFFFF; pWdata_i = ~exp_mem[4];
        @(negedge pClk_i);
        pReq_i = 1'b0;
        chk("wr_pre_we", 32'(pWe_o), 32'h0000FFFF);
        nRst_i = 1'b0;
        #1;
        chk("wr_rst_we", 32'(pWe_o), 32'd0);
        chk("wr_rst_wl", 32'(pWl_o), 32'd0);
        @(negedge pClk_i);
        nRst_i = 1'b1;
        @(negedge pClk_i);
        txn(1'b0, 4'd4, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b0);

        // Randomized traffic, including out-of-range rows and timeouts.
        for (int n = 0; n < 40; n++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            txn(wr, 4'($urandom_range(0, 13)), 16'($urandom), 16'($urandom), 2'($urandom),
                !wr && ($urandom_range(0, 7) == 0), 1'($urandom));
        end

`ifdef EPL_WRITE_VERIFY_EN
        stuck0 = 1'b1;
        txn(1'b1, 4'd5, 16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b0);
        chk("verify_stuck_err", 32'(pErr_o), 32'd1);
        txn(1'b1, 4'd5, 16'hFFFE, 16'h0001, 2'b00, 1'b0, 1'b0);
        stuck0 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
